// File: rtl/gen_alu_op_scheduler.sv
// rtl/gen_alu_op_scheduler.sv - shares one WIDTH-bit op unit between NUM_REQ requesters
// Arbitrate, latch winner's op/operand, run 1 or EXEC_CYCLES cycles, return tagged result.
module gen_alu_op_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int WIDTH       = 8,
    parameter int RR_EN       = 1,
    parameter int EXEC_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [3*NUM_REQ-1:0]     op,
    input  logic [WIDTH*NUM_REQ-1:0] data_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data
);

    localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
    localparam logic [WIDTH-1:0] HI_MASK = {{(WIDTH/2){1'b1}}, {(WIDTH/2){1'b0}}};
    localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       lat_op;
    logic [WIDTH-1:0] lat_data;
    logic [ID_W-1:0]  winner;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             take;

    assign take = (state == IDLE) && (|req);

    generate
        if ((NUM_REQ > 1) && (RR_EN != 0)) begin : g_rr
            logic [ID_W-1:0] rr_ptr;
            logic            found;
            int              idx;

            // Search starts just past the last winner so every requester gets a turn.
            always_comb begin
                winner = '0;
                found  = 1'b0;
                idx    = 0;
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                    if (!found && req[idx]) begin
                        found  = 1'b1;
                        winner = ID_W'(idx);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) rr_ptr <= ID_W'(NUM_REQ - 1);
                else if (take) rr_ptr <= winner;
            end
        end else begin : g_fp
            always_comb begin
                winner = '0;
                for (int i = NUM_REQ - 1; i >= 0; i--) begin
                    if (req[i]) winner = ID_W'(i);
                end
            end
        end
    endgenerate

    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_op   = op[3*i +: 3];
                sel_data = data_in[WIDTH*i +: WIDTH];
            end
        end
    end

    function automatic logic [WIDTH-1:0] alu(input logic [2:0] o, input logic [WIDTH-1:0] d);
        case (o)
            3'd0:    alu = d + WIDTH'(1);
            3'd1:    alu = d - WIDTH'(1);
            3'd2:    alu = {d[WIDTH-2:0], 1'b0};
            3'd3:    alu = {1'b0, d[WIDTH-1:1]};
            3'd4:    alu = d & HI_MASK;
            3'd5:    alu = d | LO_MASK;
            3'd6:    alu = ~d;
            default: alu = d;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            cnt       <= '0;
            lat_op    <= '0;
            lat_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        gnt      <= NUM_REQ'(1) << winner;
                        rsp_id   <= winner;
                        lat_op   <= sel_op;
                        lat_data <= sel_data;
                        cnt      <= (sel_op == 3'd2 || sel_op == 3'd3) ?
                                    CNT_W'(EXEC_CYCLES - 1) : '0;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    gnt <= '0;
                    if (cnt == '0) begin
                        rsp_data  <= alu(lat_op, lat_data);
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
